// File: rtl/decompress_pkg.sv
// decompress_pkg: shared types, widths and code-word decode for the run-length decompressor
package decompress_pkg;
  localparam int CODE_W = 6;
  localparam int ZR_W = 3;
  localparam int OR_W = 2;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, ZEROS, ONES, FLUSH, DONE} state_t;
  // Returns {zeros, ones}; the one-run field only counts when its top bit is set.
  function automatic logic [ZR_W+OR_W-1:0] decode(input logic [CODE_W-1:0] code);
    return {code[5:3], code[2] ? code[1:0] : 2'b00};
  endfunction
endpackage

// File: rtl/decompress_byte_packer.sv
// decompress_byte_packer: packs bits MSB-first into a byte register with a stalling output handshake
module decompress_byte_packer
  import decompress_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              bit_val,
  input  logic              flush,
  input  logic              out_ready,
  output logic              stall,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic [3:0]        bit_idx
);
  logic [BYTE_W-1:0] buffer, buf_n;
  logic [2:0] pos;
  logic wr, emit;
  always_comb begin
    stall = out_valid && !out_ready;
    wr = wr_en && !stall;
    emit = (wr && pos == 3'd7) || (flush && !stall && pos != 3'd0);
    buf_n = buffer | (BYTE_W'(bit_val) << (3'd7 - pos));
  end
  assign bit_idx = {1'b0, pos};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer <= '0;
      pos <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (clr) begin
      buffer <= '0;
      pos <= '0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_data <= wr ? buf_n : buffer;
      out_valid <= 1'b1;
      buffer <= '0;
      pos <= '0;
    end else begin
      if (wr) begin
        buffer <= buf_n;
        pos <= pos + 3'd1;
      end
      if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/decompress_ctrl.sv
// decompress_ctrl: fetches run-length codes, expands them into zero/one runs and drives the byte packer
module decompress_ctrl #(
  parameter int IDX_W = 32,
  parameter int ZR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [5:0]       code_data,
  input  logic             code_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [IDX_W-1:0] out_byte_idx,
  output logic [3:0]       bit_idx,
  output logic             busy,
  output logic             done
);
  import decompress_pkg::*;
  state_t state, state_n;
  logic [ZR_W-1:0] zcnt;
  logic [OR_W-1:0] ocnt;
  logic last;
  logic [IDX_W-1:0] cnt;
  logic [2:0] z_in;
  logic [1:0] o_in;
  logic stall, wr_en, bit_val, flush, clr, adv;
  assign {z_in, o_in} = decode(code_data);
  assign out_byte_idx = cnt;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    clr = 1'b0;
    code_ready = state == FETCH;
    wr_en = state == ZEROS || state == ONES;
    bit_val = state == ONES;
    flush = state == FLUSH;
    adv = wr_en && !stall;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = FETCH;
        clr = 1'b1;
      end
      FETCH: if (code_valid) state_n = |z_in ? ZEROS : |o_in ? ONES : code_last ? FLUSH : FETCH;
      ZEROS: if (adv && zcnt == ZR_W'(1)) state_n = |ocnt ? ONES : last ? FLUSH : FETCH;
      ONES: if (adv && ocnt == 2'd1) state_n = last ? FLUSH : FETCH;
      // Completion waits for the partial byte to be emitted and the last byte to be taken.
      FLUSH: if (bit_idx == 4'd0 && (!out_valid || out_ready)) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      zcnt <= '0;
      ocnt <= '0;
      last <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (clr) cnt <= '0;
      else if (out_valid && out_ready) cnt <= cnt + 1'b1;
      if (code_ready && code_valid) begin
        zcnt <= ZR_W'(z_in);
        ocnt <= o_in;
        last <= code_last;
      end else if (adv) begin
        if (state == ZEROS) zcnt <= zcnt - ZR_W'(1);
        else ocnt <= ocnt - 2'd1;
      end
    end
  end
  decompress_byte_packer u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .wr_en(wr_en),
    .bit_val(bit_val),
    .flush(flush),
    .out_ready(out_ready),
    .stall(stall),
    .out_valid(out_valid),
    .out_data(out_data),
    .bit_idx(bit_idx)
  );
endmodule

// File: doc/decompress_ctrl.md
# decompress_ctrl

Sequencing controller for the run-length decompression datapath: pulls 6-bit run-length code words from an upstream stream, expands each into a zero run followed by a one run, and packs the bits MSB-first into output bytes with byte/bit cursors. It sits between the compressed-input buffer and the decompressed-output memory, owns all handshakes, and signals completion to the IO-module top.

## Interface
Parameters:
- IDX_W, 32, width of the output byte index.
- ZR_W, 3, width of the zero-run field.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a decompression job; sampled only in IDLE.
- code_valid  in  1  code word available.
- code_ready  out  1  controller accepts the code word this cycle.
- code_data  in  6  [5:3] zero-run length z (0..7); [2:0] one-run field o.
- code_last  in  1  qualifies the final code word of the job.
- out_valid  out  1  packed byte available.
- out_ready  in  1  downstream accepts the byte.
- out_data  out  8  packed byte, first expanded bit in [7].
- out_byte_idx  out  IDX_W  index of the byte in out_data; equals the count of bytes already accepted.
- bit_idx  out  4  next bit position in the current byte, 0..7 (0 = bit 7).
- busy  out  1  job in progress.
- done  out  1  high in DONE until the next accepted start.

## Operation
- Code decode: zeros = code_data[5:3]; ones = code_data[2] ? code_data[1:0] : 0. Code 101 gives 1 one, 110 gives 2, 111 gives 3. Codes 0xx give 0 ones.
- States: IDLE, FETCH, ZEROS, ONES, FLUSH, DONE.
- IDLE: code_ready=0. When start=1, clear byte counter, bit_idx and the byte buffer, set busy, and go to FETCH.
- FETCH: code_ready=1. On code_valid, latch zeros, ones and last.
  - zeros>0 → ZEROS.
  - Else ones>0 → ONES.
  - Else, if last → FLUSH; if not last → FETCH.
- ZEROS: write one 0 bit per cycle at buffer[7-bit_idx] and decrement the run count. On the final zero, go to ONES if ones>0, else FLUSH if last, else FETCH.
- ONES: write one 1 bit per cycle, same pattern. After the final one, go to FLUSH if last, else FETCH.
- Byte complete: the write at bit_idx=7 loads the byte into the out_data register, sets out_valid, clears the buffer and sets bit_idx to 0.
- FLUSH:
  - bit_idx≠0: emit the partial byte with unwritten bits 0, then go to DONE after that byte is accepted.
  - bit_idx=0: go to DONE directly once out_valid is low.
- DONE: busy=0, done=1. start → clear and FETCH.
- Output handshake: out_byte_idx increments on out_valid&&out_ready, and out_valid clears on that edge.
- Backpressure: while out_valid=1 and out_ready=0, ZEROS/ONES bit writes and FLUSH emission stall. FETCH may still accept a code word.
- Simultaneous events:
  - A completing write whose previous byte is accepted in the same cycle is allowed; out_valid stays high and the new data is loaded.
  - start while busy is ignored.
  - code_valid outside FETCH is not consumed.
- bit_idx wraps 7→0 only through byte completion. The byte counter wraps modulo 2^IDX_W without a flag.

## Timing
- Reset values: code_ready 0, out_valid 0, out_data 0, out_byte_idx 0, bit_idx 0, busy 0, done 0, state IDLE.
- Reset mid-operation: all state returns to reset values on the next edge. The pending byte and the partial buffer are discarded.
- Job start: start in IDLE gives code_ready=1 on the following cycle.
- Per code word, with no stall: 1 FETCH cycle + zeros + ones cycles. Example: (011,111) takes 7 cycles.
- Byte latency: out_valid rises on the edge that writes bit 7, i.e. the cycle after that bit's ZEROS/ONES cycle starts.
- Completion: done rises 1 cycle after the last byte handshake, or 1 cycle after FLUSH entry when no partial byte remains.

## Structure
- Package decompress_pkg:
  - state enum;
  - CODE_W=6, ZR_W=3, OR_W=2, BYTE_W=8;
  - decode function returning {zeros, ones}.
- Sub-module decompress_byte_packer: buffer, bit_idx, out_data/out_valid register and stall logic. Inputs: bit value, write enable, flush, out_ready.
- The top holds the FSM, the run counters and the byte counter.

## Test plan
- Single code (001,101) with last → one byte 0x40, out_byte_idx 0, then done=1, busy=0.
- Codes (001,110),(010,111) with last → bits 0 11 00 111 give exactly one byte 0x67, no flush byte; final bit_idx 0.
- Two codes (111,111) with last → bytes 0x01, 0xC0, 0x70 (padded), out_byte_idx 0,1,2.
- Code (000,000) followed by (001,101) with last → the first code consumes 1 cycle and no bits; output 0x40.
- out_ready held low 5 cycles during the 0xC0 byte → out_data stable, bit_idx frozen, no bits lost; same bytes as the two-(111,111) test.
- rst_n low during ONES of a job → next edge gives all outputs 0 and IDLE. A new start then reproduces 0x40 for (001,101) with last.
